// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator / capture family.
//   - pwm_state_e : FSM state encoding used by pwm_capture (and generators)
//   - PWM_STATE_BITS : width of the encoded state
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_STATE_BITS = 2;

    // Encoding is fixed so that waveform tools and generators agree on values.
    typedef enum logic [PWM_STATE_BITS-1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_capture_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous input into the clk domain through a SYNC_STAGES-deep
// flop chain, keeps the previous synchronized value and flags edges.
// Ports:
//   clk   in   system clock, rising edge
//   reset in   asynchronous active-high reset; chain and prev cleared to 0
//   din   in   asynchronous input
//   s     out  synchronized input (last flop of the chain)
//   rise  out  s & ~prev, one cycle wide
//   fall  out  ~s & prev, one cycle wide
// Because the chain clears to 0, an input that is high when reset releases is
// seen as a rising edge once it reaches the end of the chain.
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain shifts din in at bit 0; prev tracks the chain output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign s    = sync_r[SYNC_STAGES-1];
    assign rise = s & ~prev_r;
    assign fall = ~s & prev_r;

endmodule : sync_edge_detect

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures an incoming PWM waveform. For every complete PWM cycle (rise to
// next rise) it reports the high time and the period in clk cycles together
// with a one-cycle valid strobe. An input that stays high or low long enough
// to saturate the counter is flagged as stuck.
// Parameters:
//   CNT_BITS    width of the counters; max measurable value is 2^CNT_BITS-1
//   SYNC_STAGES depth of the pwm_in synchronizer (>= 2)
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   enable     in   1 = capture running, 0 = FSM held in IDLE
//   pwm_in     in   asynchronous PWM input
//   high_time  out  high cycles of the last complete PWM cycle
//   period     out  cycles between the last two rising edges
//   meas_valid out  one-cycle strobe, high_time/period just updated
//   stuck_high out  input high for >= 2^CNT_BITS-1 cycles
//   stuck_low  out  input low (cycle not closed) for >= 2^CNT_BITS-1 cycles
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwm_in,
    output logic [CNT_BITS-1:0] high_time,
    output logic [CNT_BITS-1:0] period,
    output logic                meas_valid,
    output logic                stuck_high,
    output logic                stuck_low
);

    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // Synchronized input and its edges
    logic s_s;
    logic rise_s;
    logic fall_s;

    // Cycle counter, restarted on every rising edge
    logic [CNT_BITS-1:0] cnt_r;
    logic                cnt_sat_s;

    // FSM
    pwm_state_e state_r;
    pwm_state_e next_state_s;

    // Captured high time of the cycle in progress
    logic [CNT_BITS-1:0] hcap_r;
    logic [CNT_BITS-1:0] hcap_s;

    // Output registers and their next values
    logic [CNT_BITS-1:0] high_time_r;
    logic [CNT_BITS-1:0] high_time_s;
    logic [CNT_BITS-1:0] period_r;
    logic [CNT_BITS-1:0] period_s;
    logic                meas_valid_r;
    logic                meas_valid_s;
    logic                stuck_high_r;
    logic                stuck_high_s;
    logic                stuck_low_r;
    logic                stuck_low_s;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .s     (s_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign cnt_sat_s = (cnt_r == CNT_MAX);

    // Cycle counter: a rise restarts at 1 so that cnt equals the number of
    // cycles since the edge; it saturates instead of wrapping so a stalled
    // input is detectable. Disabling clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (!enable) begin
            cnt_r <= CNT_ZERO;
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (!cnt_sat_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state and next-output logic. A cycle is only reported when it was
    // both started and closed by rises seen in HIGH/LOW; saturation drops the
    // FSM to IDLE so the partial cycle is never reported.
    always_comb begin
        next_state_s = state_r;
        hcap_s       = hcap_r;
        high_time_s  = high_time_r;
        period_s     = period_r;
        meas_valid_s = 1'b0;
        stuck_high_s = stuck_high_r;
        stuck_low_s  = stuck_low_r;

        if (!enable) begin
            next_state_s = IDLE;
        end else begin
            // Any rise proves the input is toggling again.
            if (rise_s) begin
                stuck_high_s = 1'b0;
                stuck_low_s  = 1'b0;
            end else begin
                stuck_high_s = stuck_high_r;
                stuck_low_s  = stuck_low_r;
            end

            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        next_state_s = HIGH;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                HIGH: begin
                    // A fall on the saturating cycle is still a valid high
                    // time of exactly CNT_MAX, so the fall is checked first.
                    if (fall_s) begin
                        hcap_s       = cnt_r;
                        next_state_s = LOW;
                    end else if (cnt_sat_s && s_s) begin
                        stuck_high_s = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = HIGH;
                    end
                end
                LOW: begin
                    // A rise on the saturating cycle closes a valid period.
                    if (rise_s) begin
                        high_time_s  = hcap_r;
                        period_s     = cnt_r;
                        meas_valid_s = 1'b1;
                        next_state_s = HIGH;
                    end else if (cnt_sat_s && !s_s) begin
                        stuck_low_s  = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = LOW;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // FSM state, captured high time and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            hcap_r       <= CNT_ZERO;
            high_time_r  <= CNT_ZERO;
            period_r     <= CNT_ZERO;
            meas_valid_r <= 1'b0;
            stuck_high_r <= 1'b0;
            stuck_low_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            hcap_r       <= hcap_s;
            high_time_r  <= high_time_s;
            period_r     <= period_s;
            meas_valid_r <= meas_valid_s;
            stuck_high_r <= stuck_high_s;
            stuck_low_r  <= stuck_low_s;
        end
    end

    assign high_time  = high_time_r;
    assign period     = period_r;
    assign meas_valid = meas_valid_r;
    assign stuck_high = stuck_high_r;
    assign stuck_low  = stuck_low_r;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
// Directed and randomized stimulus for pwm_capture (CNT_BITS=8,
// SYNC_STAGES=2). Expected outputs come from a timestamp-based model of the
// measurement rules: it remembers when the current PWM cycle rose and fell
// and reports a measurement when the next rise closes an armed cycle.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int CB    = 8;
    localparam int MAXV  = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          pwm_in;
    logic [CB-1:0] high_time;
    logic [CB-1:0] period;
    logic          meas_valid;
    logic          stuck_high;
    logic          stuck_low;

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int strobe_mark;

    // Reference model state
    int       cyc;
    logic     ph [0:3];
    bit       armed;
    bit       fell;
    int       t_rise;
    int       t_fall;
    logic [7:0] m_ht;
    logic [7:0] m_per;
    logic       m_valid;
    logic       m_sh;
    logic       m_sl;

    pwm_capture #(
        .CNT_BITS    (CB),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .high_time  (high_time),
        .period     (period),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 4; i++) ph[i] = 1'b0;
        armed = 1'b0;
        fell = 1'b0;
        t_rise = 0;
        t_fall = 0;
        m_ht = 8'd0;
        m_per = 8'd0;
        m_valid = 1'b0;
        m_sh = 1'b0;
        m_sl = 1'b0;
    endtask

    // One clock of the model. The input seen by the measurement logic is the
    // PWM input delayed by the two synchronizer stages.
    task automatic model_clock(input logic p, input logic e);
        logic s;
        logic prv;
        ph[3] = ph[2];
        ph[2] = ph[1];
        ph[1] = ph[0];
        ph[0] = p;
        s = ph[2];
        prv = ph[3];
        m_valid = 1'b0;
        if (!e) begin
            armed = 1'b0;
        end else if (s && !prv) begin
            if (armed && fell) begin
                m_ht = 8'(t_fall - t_rise);
                m_per = 8'(cyc - t_rise);
                m_valid = 1'b1;
            end
            m_sh = 1'b0;
            m_sl = 1'b0;
            armed = 1'b1;
            fell = 1'b0;
            t_rise = cyc;
        end else if (armed) begin
            if (!s && prv && !fell) begin
                fell = 1'b1;
                t_fall = cyc;
            end else if (cyc - t_rise >= MAXV) begin
                if (fell) m_sl = 1'b1;
                else m_sh = 1'b1;
                armed = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_all();
        check("high_time", high_time, m_ht);
        check("period", period, m_per);
        check("meas_valid", {7'd0, meas_valid}, {7'd0, m_valid});
        check("stuck_high", {7'd0, stuck_high}, {7'd0, m_sh});
        check("stuck_low", {7'd0, stuck_low}, {7'd0, m_sl});
    endtask

    task automatic tick(input logic p, input logic e);
        pwm_in = p;
        enable = e;
        @(posedge clk);
        model_clock(p, e);
        #1;
        check_all();
        if (meas_valid === 1'b1) n_strobe++;
    endtask

    task automatic wave(input int per, input int hi, input int n, input logic e);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < per; j++)
                tick(j < hi, e);
    endtask

    task automatic hold(input logic p, input int n, input logic e);
        for (int i = 0; i < n; i++) tick(p, e);
    endtask

    initial begin
        int per;
        int hi;
        logic en;

        reset = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // 1: period 10 high 3, first rise only arms
        wave(10, 3, 5, 1'b1);
        check("s1_strobes", 8'(n_strobe), 8'd4);
        check("s1_high_time", high_time, 8'd3);
        check("s1_period", period, 8'd10);

        // 2: toggling every clock, minimum measurable cycle
        wave(2, 1, 10, 1'b1);
        hold(1'b0, 3, 1'b1);
        check("s2_high_time", high_time, 8'd1);
        check("s2_period", period, 8'd2);

        // 3: held high, then a normal wave
        hold(1'b1, 200, 1'b1);
        check("s3_not_yet_stuck", {7'd0, stuck_high}, 8'd0);
        hold(1'b1, 100, 1'b1);
        check("s3_stuck_high", {7'd0, stuck_high}, 8'd1);
        wave(10, 3, 3, 1'b1);
        hold(1'b0, 2, 1'b1);
        check("s3_cleared", {7'd0, stuck_high}, 8'd0);
        check("s3_high_time", high_time, 8'd3);
        check("s3_period", period, 8'd10);

        // 4: held low after a valid measurement
        hold(1'b0, 300, 1'b1);
        check("s4_stuck_low", {7'd0, stuck_low}, 8'd1);
        check("s4_high_time_held", high_time, 8'd3);
        check("s4_period_held", period, 8'd10);

        // 5: enable dropped mid-HIGH, then raised
        hold(1'b1, 5, 1'b1);
        strobe_mark = n_strobe;
        wave(10, 3, 2, 1'b0);
        check("s5_no_strobe_disabled", 8'(n_strobe - strobe_mark), 8'd0);
        wave(10, 3, 3, 1'b1);
        check("s5_strobes_after_enable", 8'(n_strobe - strobe_mark), 8'd2);

        // 6: asynchronous reset mid-LOW
        wave(10, 3, 2, 1'b1);
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        check("s6_high_time_zero", high_time, 8'd0);
        reset = 1'b0;
        strobe_mark = n_strobe;
        hold(1'b1, 5, 1'b1);
        hold(1'b0, 5, 1'b1);
        check("s6_arm_only", 8'(n_strobe - strobe_mark), 8'd0);
        wave(7, 2, 3, 1'b1);

        // Randomized waves with occasional disabled periods
        for (int k = 0; k < 40; k++) begin
            per = $urandom_range(2, 40);
            hi = $urandom_range(1, per - 1);
            en = ($urandom_range(0, 9) != 0);
            wave(per, hi, 1, en);
        end
        hold(1'b0, 5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pwm_capture
